// File: rtl/param_cpu_pkg.sv
// param_cpu_pkg -- shared definitions for the param_cpu core.
//   * op-byte constants and op-field group codes used by the decoder
//   * FSM state encoding
//   * ALU operation select and the op-byte -> ALU select mapping
package param_cpu_pkg;

  // Whole-byte opcodes
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_HLT = 8'h76;
  localparam logic [7:0] OP_CMA = 8'h2F;
  localparam logic [7:0] OP_JMP = 8'hC3;

  // Field codes: op[7:6] group, op[2:0] low field
  localparam logic [1:0] GRP_LOW = 2'b00;  // MVI lives here
  localparam logic [1:0] GRP_MOV = 2'b01;
  localparam logic [1:0] GRP_JNZ = 2'b11;
  localparam logic [2:0] LOW_MVI = 3'b110;
  localparam logic [2:0] LOW_JNZ = 3'b010;

  // op[7:3] for register-source ALU instructions
  localparam logic [4:0] ALU_GRP_ADD = 5'b10000;
  localparam logic [4:0] ALU_GRP_ADC = 5'b10001;
  localparam logic [4:0] ALU_GRP_SUB = 5'b10010;
  localparam logic [4:0] ALU_GRP_ANA = 5'b10100;
  localparam logic [4:0] ALU_GRP_XRA = 5'b10101;
  localparam logic [4:0] ALU_GRP_ORA = 5'b10110;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_REPORT = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_ADC  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_NOT  = 3'd6,
    ALU_PASS = 3'd7   // also means "not a register-source ALU op"
  } alu_op_e;

  // Map op[7:3] to an ALU select; ALU_PASS for anything that is not ADD..ORA.
  function automatic alu_op_e alu_sel_f(input logic [4:0] grp);
    alu_op_e sel;
    case (grp)
      ALU_GRP_ADD: sel = ALU_ADD;
      ALU_GRP_ADC: sel = ALU_ADC;
      ALU_GRP_SUB: sel = ALU_SUB;
      ALU_GRP_ANA: sel = ALU_AND;
      ALU_GRP_XRA: sel = ALU_XOR;
      ALU_GRP_ORA: sel = ALU_OR;
      default:     sel = ALU_PASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/param_cpu_alu.sv
// param_cpu_alu -- combinational arithmetic/logic unit of param_cpu.
// Ports:
//   a, b  : DATA_W operands (a is the accumulator)
//   cin   : incoming carry flag
//   op    : ALU operation select (alu_op_e)
//   y     : DATA_W result
//   cout  : carry flag after the operation
// Carry rules: ADD/ADC carry-out of the sum, SUB unsigned borrow,
// logic ops clear carry, NOT/PASS keep the incoming carry.
module param_cpu_alu
  import param_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] y,
  output logic              cout
);

  logic [DATA_W:0] sum_s;

  // Result and carry selection for each ALU operation.
  always_comb begin
    sum_s = {(DATA_W+1){1'b0}};
    y     = a;
    cout  = cin;
    case (op)
      ALU_ADD: begin
        sum_s = {1'b0, a} + {1'b0, b};
        y     = sum_s[DATA_W-1:0];
        cout  = sum_s[DATA_W];
      end
      ALU_ADC: begin
        sum_s = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
        y     = sum_s[DATA_W-1:0];
        cout  = sum_s[DATA_W];
      end
      ALU_SUB: begin
        y    = a - b;
        cout = (a < b);
      end
      ALU_AND: begin
        y    = a & b;
        cout = 1'b0;
      end
      ALU_XOR: begin
        y    = a ^ b;
        cout = 1'b0;
      end
      ALU_OR: begin
        y    = a | b;
        cout = 1'b0;
      end
      ALU_NOT: begin
        y    = ~a;
        cout = cin;
      end
      ALU_PASS: begin
        y    = b;
        cout = cin;
      end
      default: begin
        y    = a;
        cout = cin;
      end
    endcase
  end

endmodule

// File: rtl/param_cpu.sv
// param_cpu -- small multi-cycle accumulator CPU with a ready/valid
// retired-instruction report port.
// Optional feature: define PARAM_CPU_JNZ_EN to decode 11sss010 as
// JNZ rs,imm (otherwise that pattern is a reported NOP).
// Ports:
//   clk, rst (synchronous, active-low)
//   start                               : run from pc 0 (accepted in IDLE/HALT)
//   imem_we, imem_addr, imem_wdata      : instruction-memory write port
//   out_valid, out_ready                : report handshake
//   out_opcode, out_pc, out_result,
//   out_carry                           : report payload
//   halted                              : core is in HALT
module param_cpu
  import param_cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int IMEM_AW = 7,
  localparam int INSTR_W = 8 + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_opcode,
  output logic [IMEM_AW-1:0] out_pc,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_carry,
  output logic               halted
);

  logic [INSTR_W-1:0] imem_r [2**IMEM_AW];

  state_e             state_r, state_s;
  logic [IMEM_AW-1:0] pc_r;
  logic [INSTR_W-1:0] ir_r;
  logic [DATA_W-1:0]  regs_r [8];
  logic               carry_r;

  // operands and pending write-back
  logic [DATA_W-1:0]  a_r, b_r;
  alu_op_e            alu_sel_r;
  logic               wb_en_r;
  logic [2:0]         wb_dst_r;
  logic [DATA_W-1:0]  wb_data_r;
  logic               wb_carry_r;

  logic [DATA_W-1:0]  alu_y_s;
  logic               alu_cout_s;

  // decode results
  logic [7:0]         op_s;
  logic [DATA_W-1:0]  imm_s;
  logic [IMEM_AW-1:0] jmp_tgt_s;
  logic [IMEM_AW-1:0] pc_inc_s;
  logic               dec_hlt_s, dec_jmp_s, dec_jnz_s, dec_alu_s, dec_wr_s;
  logic               jnz_taken_s;
  alu_op_e            dec_sel_s;
  logic [2:0]         dec_dst_s;
  logic [DATA_W-1:0]  dec_data_s;

  assign op_s      = ir_r[INSTR_W-1 -: 8];
  assign imm_s     = ir_r[DATA_W-1:0];
  assign jmp_tgt_s = IMEM_AW'(imm_s);
  assign pc_inc_s  = pc_r + {{(IMEM_AW-1){1'b0}}, 1'b1};

  assign halted    = (state_r == S_HALT);

  param_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a    (a_r),
    .b    (b_r),
    .cin  (carry_r),
    .op   (alu_sel_r),
    .y    (alu_y_s),
    .cout (alu_cout_s)
  );

  // Instruction decode of the held instruction register.
  always_comb begin
    dec_hlt_s   = 1'b0;
    dec_jmp_s   = 1'b0;
    dec_jnz_s   = 1'b0;
    dec_alu_s   = 1'b0;
    dec_wr_s    = 1'b0;
    dec_sel_s   = ALU_PASS;
    dec_dst_s   = 3'd0;
    dec_data_s  = {DATA_W{1'b0}};
    jnz_taken_s = 1'b0;
    // HLT shares the MOV group, so it must be tested first
    if (op_s == OP_HLT) begin
      dec_hlt_s = 1'b1;
    end else if (op_s == OP_JMP) begin
      dec_jmp_s = 1'b1;
    end else if (op_s == OP_CMA) begin
      dec_alu_s = 1'b1;
      dec_sel_s = ALU_NOT;
      dec_wr_s  = 1'b1;
    end else if (op_s[7:6] == GRP_MOV) begin
      dec_wr_s   = 1'b1;
      dec_dst_s  = op_s[5:3];
      dec_data_s = regs_r[op_s[2:0]];
    end else if ((op_s[7:6] == GRP_LOW) && (op_s[2:0] == LOW_MVI)) begin
      dec_wr_s   = 1'b1;
      dec_dst_s  = op_s[5:3];
      dec_data_s = imm_s;
    end else if (alu_sel_f(op_s[7:3]) != ALU_PASS) begin
      dec_alu_s = 1'b1;
      dec_sel_s = alu_sel_f(op_s[7:3]);
      dec_wr_s  = 1'b1;
`ifdef PARAM_CPU_JNZ_EN
    end else if ((op_s[7:6] == GRP_JNZ) && (op_s[2:0] == LOW_JNZ)) begin
      dec_jnz_s   = 1'b1;
      jnz_taken_s = (regs_r[op_s[5:3]] != {DATA_W{1'b0}});
`endif
    end else begin
      // NOP and every undefined op byte: reported, nothing written
      dec_wr_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_FETCH;
        else       state_s = S_IDLE;
      end
      S_FETCH:  state_s = S_DECODE;
      S_DECODE: begin
        if (dec_hlt_s)                   state_s = S_HALT;
        else if (dec_jmp_s || dec_jnz_s) state_s = S_FETCH;
        else if (dec_alu_s)              state_s = S_EXEC;
        else                             state_s = S_WB;
      end
      S_EXEC:   state_s = S_WB;
      S_WB:     state_s = S_REPORT;
      S_REPORT: begin
        if (out_ready) state_s = S_FETCH;
        else           state_s = S_REPORT;
      end
      S_HALT: begin
        if (start) state_s = S_FETCH;
        else       state_s = S_HALT;
      end
      default:  state_s = S_IDLE;
    endcase
  end

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_r[imem_addr] <= imem_wdata;
    end
  end

  // Datapath: fetch, operand capture, execute, write-back and report.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r       <= {IMEM_AW{1'b0}};
      ir_r       <= {INSTR_W{1'b0}};
      carry_r    <= 1'b0;
      for (int i = 0; i < 8; i++) regs_r[i] <= {DATA_W{1'b0}};
      a_r        <= {DATA_W{1'b0}};
      b_r        <= {DATA_W{1'b0}};
      alu_sel_r  <= ALU_PASS;
      wb_en_r    <= 1'b0;
      wb_dst_r   <= 3'd0;
      wb_data_r  <= {DATA_W{1'b0}};
      wb_carry_r <= 1'b0;
      out_valid  <= 1'b0;
      out_opcode <= 8'h00;
      out_pc     <= {IMEM_AW{1'b0}};
      out_result <= {DATA_W{1'b0}};
      out_carry  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_HALT: begin
          if (start) pc_r <= {IMEM_AW{1'b0}};
        end
        S_FETCH: begin
          // a same-cycle write to this address lands after the read
          ir_r <= imem_r[pc_r];
        end
        S_DECODE: begin
          a_r        <= regs_r[0];
          b_r        <= regs_r[op_s[2:0]];
          alu_sel_r  <= dec_sel_s;
          wb_en_r    <= dec_wr_s;
          wb_dst_r   <= dec_dst_s;
          wb_data_r  <= dec_data_s;
          wb_carry_r <= carry_r;
          if (dec_jmp_s) begin
            pc_r <= jmp_tgt_s;
          end else if (dec_jnz_s) begin
            pc_r <= jnz_taken_s ? jmp_tgt_s : pc_inc_s;
          end
        end
        S_EXEC: begin
          wb_data_r  <= alu_y_s;
          wb_carry_r <= alu_cout_s;
        end
        S_WB: begin
          if (wb_en_r) regs_r[wb_dst_r] <= wb_data_r;
          carry_r    <= wb_carry_r;
          pc_r       <= pc_inc_s;
          out_valid  <= 1'b1;
          out_opcode <= op_s;
          out_pc     <= pc_r;
          out_result <= wb_en_r ? wb_data_r : {DATA_W{1'b0}};
          out_carry  <= wb_carry_r;
        end
        S_REPORT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_cpu.sv
// tb_param_cpu -- directed self-checking bench for param_cpu
// (DATA_W=8, IMEM_AW=7). Honours PARAM_CPU_JNZ_EN like the design.
module tb_param_cpu;

  localparam int DATA_W  = 8;
  localparam int IMEM_AW = 7;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_opcode;
  logic [IMEM_AW-1:0] out_pc;
  logic [DATA_W-1:0]  out_result;
  logic               out_carry;
  logic               halted;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]         r_op;
  logic [IMEM_AW-1:0] r_pc;
  logic [DATA_W-1:0]  r_res;
  logic               r_carry;
  int                 r_lat;

  typedef struct {
    logic [6:0] pc;
    logic [7:0] op;
    logic [7:0] res;
    logic       c;
    int         lat;   // 0: latency not checked
  } exp_t;
  exp_t tbl[$];

  always #5 clk = ~clk;

  param_cpu #(.DATA_W(DATA_W), .IMEM_AW(IMEM_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_pc     (out_pc),
    .out_result (out_result),
    .out_carry  (out_carry),
    .halted     (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic write_instr(input logic [6:0] a, input logic [7:0] op, input logic [7:0] imm);
    imem_we    = 1'b1;
    imem_addr  = a;
    imem_wdata = {op, imm};
    @(negedge clk);
    imem_we    = 1'b0;
  endtask

  // Wait (bounded) for out_valid and capture the report.
  task automatic get_report(input string tag);
    int lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    r_op = out_opcode; r_pc = out_pc; r_res = out_result; r_carry = out_carry; r_lat = lat;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int bad;
    int seen;
    rst = 1'b0; start = 1'b0; imem_we = 1'b0; imem_addr = 7'd0;
    imem_wdata = 16'h0000; out_ready = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_valid",  {31'd0, out_valid}, 32'd0);
    check_eq("rst_halted", {31'd0, halted},    32'd0);
    check_eq("rst_opcode", {24'd0, out_opcode}, 32'd0);
    check_eq("rst_pc",     {25'd0, out_pc},     32'd0);
    check_eq("rst_result", {24'd0, out_result}, 32'd0);
    check_eq("rst_carry",  {31'd0, out_carry},  32'd0);

    // program (loaded during reset; memory is not cleared by reset)
    write_instr(7'd0,  8'h0E, 8'h05);  // MVI r1,05
    write_instr(7'd1,  8'h06, 8'hFB);  // MVI r0,FB
    write_instr(7'd2,  8'h81, 8'h00);  // ADD r1
    write_instr(7'd3,  8'h06, 8'h03);  // MVI r0,03
    write_instr(7'd4,  8'h91, 8'h00);  // SUB r1
    write_instr(7'd5,  8'h89, 8'h00);  // ADC r1
    write_instr(7'd6,  8'hA1, 8'h00);  // ANA r1
    write_instr(7'd7,  8'hA9, 8'h00);  // XRA r1
    write_instr(7'd8,  8'hB1, 8'h00);  // ORA r1
    write_instr(7'd9,  8'h2F, 8'h00);  // CMA
    write_instr(7'd10, 8'h50, 8'h00);  // MOV r2,r0
    write_instr(7'd11, 8'h98, 8'h00);  // undefined -> NOP
    write_instr(7'd12, 8'hCA, 8'h0E);  // JNZ r1,0E (or NOP)
    write_instr(7'd13, 8'hC3, 8'h10);  // JMP 10
    write_instr(7'd14, 8'hC3, 8'h10);  // JMP 10
    write_instr(7'd16, 8'h62, 8'h00);  // MOV r4,r2
    write_instr(7'd17, 8'h76, 8'h00);  // HLT
    write_instr(7'h7F, 8'h00, 8'h00);  // NOP at top address
    rst = 1'b1;

    repeat (5) @(negedge clk);
    check_eq("idle_no_valid", {31'd0, out_valid}, 32'd0);

    tbl.push_back('{7'd0,  8'h0E, 8'h05, 1'b0, 3});
    tbl.push_back('{7'd1,  8'h06, 8'hFB, 1'b0, 3});
    tbl.push_back('{7'd2,  8'h81, 8'h00, 1'b1, 4});
    tbl.push_back('{7'd3,  8'h06, 8'h03, 1'b1, 3});
    tbl.push_back('{7'd4,  8'h91, 8'hFE, 1'b1, 4});
    tbl.push_back('{7'd5,  8'h89, 8'h04, 1'b1, 0});
    tbl.push_back('{7'd6,  8'hA1, 8'h04, 1'b0, 0});
    tbl.push_back('{7'd7,  8'hA9, 8'h01, 1'b0, 0});
    tbl.push_back('{7'd8,  8'hB1, 8'h05, 1'b0, 0});
    tbl.push_back('{7'd9,  8'h2F, 8'hFA, 1'b0, 0});
    tbl.push_back('{7'd10, 8'h50, 8'hFA, 1'b0, 0});
    tbl.push_back('{7'd11, 8'h98, 8'h00, 1'b0, 0});
`ifndef PARAM_CPU_JNZ_EN
    tbl.push_back('{7'd12, 8'hCA, 8'h00, 1'b0, 0});
`endif
    tbl.push_back('{7'd16, 8'h62, 8'hFA, 1'b0, 0});

    pulse_start();
    foreach (tbl[i]) begin
      get_report($sformatf("rep%0d", i));
      check_eq($sformatf("pc%0d", i),     {25'd0, r_pc},    {25'd0, tbl[i].pc});
      check_eq($sformatf("op%0d", i),     {24'd0, r_op},    {24'd0, tbl[i].op});
      check_eq($sformatf("res%0d", i),    {24'd0, r_res},   {24'd0, tbl[i].res});
      check_eq($sformatf("carry%0d", i),  {31'd0, r_carry}, {31'd0, tbl[i].c});
      if (tbl[i].lat != 0) check_eq($sformatf("lat%0d", i), r_lat, tbl[i].lat);
      if (tbl[i].pc == 7'd7) begin
        bad = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (!out_valid || out_pc != 7'd7 || out_result != 8'h01 || out_opcode != 8'hA9)
            bad++;
        end
        check_eq("stall_stable", bad, 0);
      end
      accept();
    end

    // HLT: halted rises, no report for 20 cycles
    bad = 0;
    while (!halted && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    check_eq("halted_set", {31'd0, halted}, 32'd1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("halt_no_valid", seen, 0);
    check_eq("halted_hold", {31'd0, halted}, 32'd1);

    // restart from HALT
    pulse_start();
    check_eq("halted_clr", {31'd0, halted}, 32'd0);
    get_report("restart");
    check_eq("restart_pc", {25'd0, r_pc}, 32'd0);
    check_eq("restart_op", {24'd0, r_op}, 32'h0E);
    write_instr(7'd1, 8'hC3, 8'h7F);   // JMP 7F
    accept();
    get_report("top");
    check_eq("top_pc", {25'd0, r_pc}, 32'h7F);
    check_eq("top_op", {24'd0, r_op}, 32'h00);
    accept();
    get_report("wrap");
    check_eq("wrap_pc", {25'd0, r_pc}, 32'h00);

    // reset while ADD r1 sits in EXEC
    write_instr(7'd1, 8'h81, 8'h00);
    accept();                  // now in FETCH of pc 1
    @(negedge clk);            // DECODE
    @(negedge clk);            // EXEC
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("mrst_valid",  {31'd0, out_valid},  32'd0);
    check_eq("mrst_result", {24'd0, out_result}, 32'd0);
    check_eq("mrst_opcode", {24'd0, out_opcode}, 32'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid || halted) seen++;
    end
    check_eq("mrst_idle", seen, 0);

    write_instr(7'd0, 8'h48, 8'h00);  // MOV r1,r0
    write_instr(7'd1, 8'hCA, 8'h40);  // JNZ r1,40 (or NOP)
    write_instr(7'd2, 8'h59, 8'h00);  // MOV r3,r1
    pulse_start();
    get_report("r0chk");
    check_eq("r0chk_pc",    {25'd0, r_pc},    32'd0);
    check_eq("r0chk_res",   {24'd0, r_res},   32'd0);
    check_eq("r0chk_carry", {31'd0, r_carry}, 32'd0);
    accept();
`ifndef PARAM_CPU_JNZ_EN
    get_report("jnznop");
    check_eq("jnznop_pc", {25'd0, r_pc}, 32'd1);
    check_eq("jnznop_op", {24'd0, r_op}, 32'hCA);
    accept();
`endif
    get_report("fall");
    check_eq("fall_pc",  {25'd0, r_pc},  32'd2);
    check_eq("fall_res", {24'd0, r_res}, 32'd0);
    accept();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_cpu.md
PARAM_CPU -- requirements
Module: param_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register, accumulator and ALU width (>=4).
REQ-002 SHALL have parameter IMEM_AW, default 7: instruction-memory address width, so depth = 2^IMEM_AW; pc width = IMEM_AW.
REQ-003 SHALL have derived constant INSTR_W = 8 + DATA_W: instruction = {op[7:0], imm[DATA_W-1:0]}.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-low (asserted when 0, sampled on clk rising edge).
REQ-006 SHALL have port start, input, 1: one-cycle pulse; from IDLE or HALT, sets pc=0 and enters FETCH.
REQ-007 SHALL have port imem_we, input, 1: instruction-memory write enable.
REQ-008 SHALL have port imem_addr, input, IMEM_AW: write address.
REQ-009 SHALL have port imem_wdata, input, INSTR_W: write data.
REQ-010 SHALL have port out_valid, output, 1: a retired-instruction report is presented.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the report.
REQ-012 SHALL have port out_opcode, output, 8: op byte of the retired instruction.
REQ-013 SHALL have port out_pc, output, IMEM_AW: pc of the retired instruction.
REQ-014 SHALL have port out_result, output, DATA_W: value written to the destination register.
REQ-015 SHALL have port out_carry, output, 1: carry flag after the instruction.
REQ-016 SHALL have port halted, output, 1: core is in HALT.

Function
REQ-017 SHALL hold eight DATA_W registers r0..r7; r0 is the accumulator; a single carry flag.
REQ-018 SHALL decode: 0x00 NOP; 00ddd110 MVI rd,imm; 01dddsss MOV rd,rs; 0x76 HLT (overrides MOV); 10000sss ADD; 10001sss ADC; 10010sss SUB; 10100sss ANA; 10101sss XRA; 10110sss ORA; 0x2F CMA; 0xC3 JMP imm.
REQ-019 SHALL treat every other op byte as NOP.
REQ-020 SHALL use the state sequence IDLE -> FETCH -> DECODE -> {EXEC -> WB | WB} -> REPORT -> FETCH; HALT is terminal until start or reset.
REQ-021 SHALL route ALU ops through EXEC (operands registered), giving 4 cycles from FETCH to out_valid; NOP, MOV and MVI skip EXEC (3 cycles).
REQ-022 SHALL, for JMP, load pc = imm[IMEM_AW-1:0] in DECODE, return to FETCH, and produce no report.
REQ-023 SHALL compute ADD/ADC r0 = r0 + rs (+carry), with carry = bit DATA_W of the sum.
REQ-024 SHALL compute SUB r0 = r0 - rs, with carry = 1 iff r0 < rs (unsigned borrow).
REQ-025 SHALL make ANA/XRA/ORA clear carry, and CMA invert r0 while keeping carry.
REQ-026 SHALL increment pc modulo 2^IMEM_AW in WB, so 2^IMEM_AW-1 wraps to 0.
REQ-027 SHALL hold out_valid and all out_* stable in REPORT until out_ready=1; leave REPORT on the cycle out_valid&&out_ready.
REQ-028 SHALL apply imem writes at any time; a write to the address being fetched in the same cycle returns the old word.
REQ-029 SHALL ignore start outside IDLE and HALT.
REQ-030 SHALL, on HLT, set halted=1, emit no report, and stop fetching.

Reset
REQ-031 SHALL, while rst=0, force state=IDLE, pc=0, r0..r7=0, carry=0, out_valid=0, out_opcode=0, out_pc=0, out_result=0, out_carry=0, halted=0.
REQ-032 SHALL, on reset asserted mid-instruction, abandon the instruction with no register or flag update, including a pending REPORT.
REQ-033 SHALL NOT reset instruction-memory contents.

Configuration
REQ-034 SHALL, with macro PARAM_CPU_JNZ_EN defined, decode 11sss010 JNZ rs,imm: pc = imm if rs != 0, else pc+1; no report in either case.
REQ-035 SHALL, without PARAM_CPU_JNZ_EN, decode 11sss010 as NOP and emit a report.

Structure
REQ-036 SHALL place the op-byte constants, state encoding and ALU op select in shared package param_cpu_pkg.
REQ-037 SHALL place the combinational arithmetic/logic in sub-module param_cpu_alu (DATA_W parameter; inputs a, b, cin, op; outputs y, cout).

Verification (DATA_W=8, IMEM_AW=7)
REQ-038 SHALL cover: MVI r1,0x05; MVI r0,0xFB; ADD r1 -> third report out_result=0x00, out_carry=1, out_pc=2.
REQ-039 SHALL cover: r0=0x03, r1=0x05, SUB r1 -> out_result=0xFE, out_carry=1; then ANA r1 -> out_carry=0.
REQ-040 SHALL cover: out_ready held 0 for 10 cycles during REPORT -> out_valid stays 1, out_* unchanged, pc not advanced.
REQ-041 SHALL cover: NOP at address 0x7F -> next report out_pc=0x00; JMP 0x10 -> next report out_pc=0x10.
REQ-042 SHALL cover: HLT -> halted=1 and no out_valid for 20 cycles; start pulse -> halted=0 and first report out_pc=0.
REQ-043 SHALL cover: rst=0 for one edge during EXEC of ADD -> r0 and carry are 0 and state is IDLE; with PARAM_CPU_JNZ_EN, JNZ r1 with r1=0 falls through to pc+1.
